// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: select codes,
// FSM state encoding and the select legality check.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_MUL  = 4'b0100;
    localparam logic [3:0] ALU_DIV  = 4'b0101;
    localparam logic [3:0] ALU_SHL  = 4'b0110;
    localparam logic [3:0] ALU_SHR  = 4'b0111;
    localparam logic [3:0] ALU_ROL  = 4'b1000;
    localparam logic [3:0] ALU_ROR  = 4'b1001;
    localparam logic [3:0] ALU_NOR  = 4'b1010;
    localparam logic [3:0] ALU_NAND = 4'b1011;
    localparam logic [3:0] ALU_XOR  = 4'b1100;
    localparam logic [3:0] ALU_XNOR = 4'b1101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Codes 1110 and 1111 are unassigned.
    function automatic logic sel_is_legal(input logic [3:0] sel);
        return sel <= ALU_XNOR;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO, asynchronous active-high reset.
// Ports: clk, rst, i_push/i_wdata, i_pop/o_rdata (show-ahead), o_full, o_empty.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int W     = 132,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic         w_do_push;
    logic         w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the
    // lower index bits match.
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_empty = (r_wptr == r_rptr);

    // A full FIFO refuses a push even when a pop happens alongside.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational ALU: buffers requests, drives
// registered operands, returns result with zero/error flags in order.
// Ports: req_* request handshake, alu_* ALU connection, rsp_* response
// handshake. Optional macro ALU_ISSUE_STATS_EN adds stat_ops/stat_errs.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_op1,
    input  logic [WIDTH-1:0] req_op2,
    input  logic [3:0]       req_sel,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    output logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_err
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [31:0]      stat_ops,
    output logic [15:0]      stat_errs
`endif
);

    localparam int EW = 2 * WIDTH + 4;

    logic [EW-1:0]    w_wdata;
    logic [EW-1:0]    w_rdata;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_head_op1;
    logic [WIDTH-1:0] w_head_op2;
    logic [3:0]       w_head_sel;
    logic             w_legal;

    logic [1:0]       r_state;
    logic             r_avail;
    logic [WIDTH-1:0] r_alu_op1;
    logic [WIDTH-1:0] r_alu_op2;
    logic [3:0]       r_alu_sel;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_zero;
    logic             r_rsp_err;
    logic             r_rsp_valid;

    assign req_ready = !w_full;
    assign w_push    = req_valid && req_ready;
    assign w_wdata   = {req_op1, req_op2, req_sel};

    alu_cmd_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head_op1 = w_rdata[EW-1 -: WIDTH];
    assign w_head_op2 = w_rdata[WIDTH+3 -: WIDTH];
    assign w_head_sel = w_rdata[3:0];

    assign w_legal = sel_is_legal(w_head_sel) &&
                     !((w_head_sel == ALU_DIV) && (w_head_op2 == '0));

    // r_avail is a registered copy of !empty, so a new entry is seen by
    // the FSM one cycle after its push. Pops only happen in IDLE and
    // IDLE is always left for at least one cycle afterwards, so the
    // copy is up to date whenever the FSM next consults it.
    assign w_pop = (r_state == ST_IDLE) && r_avail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_avail     <= 1'b0;
            r_alu_op1   <= '0;
            r_alu_op2   <= '0;
            r_alu_sel   <= '0;
            r_rsp_data  <= '0;
            r_rsp_zero  <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_avail <= !w_empty;
            case (r_state)
                ST_IDLE: begin
                    if (r_avail) begin
                        if (w_legal) begin
                            r_alu_op1 <= w_head_op1;
                            r_alu_op2 <= w_head_op2;
                            r_alu_sel <= w_head_sel;
                            r_state   <= ST_EXEC;
                        end else begin
                            r_rsp_data  <= '0;
                            r_rsp_zero  <= 1'b0;
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end
                    end
                end
                ST_EXEC: begin
                    r_rsp_data  <= alu_out;
                    r_rsp_zero  <= (alu_out == '0);
                    r_rsp_err   <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_op1   = r_alu_op1;
    assign alu_op2   = r_alu_op2;
    assign alu_sel   = r_alu_sel;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_zero  = r_rsp_zero;
    assign rsp_err   = r_rsp_err;

`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] r_stat_ops;
    logic [15:0] r_stat_errs;
    logic        w_err_enter;

    assign w_err_enter = (r_state == ST_IDLE) && r_avail && !w_legal;

    // Both counters step on the cycle the FSM moves into RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_ops  <= '0;
            r_stat_errs <= '0;
        end else begin
            if ((r_state == ST_EXEC) && (r_stat_ops != '1))
                r_stat_ops <= r_stat_ops + 32'd1;
            if (w_err_enter && (r_stat_errs != '1))
                r_stat_errs <= r_stat_errs + 16'd1;
        end
    end

    assign stat_ops  = r_stat_ops;
    assign stat_errs = r_stat_errs;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with an attached ALU model
// and an in-order response scoreboard.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_op1;
    logic [63:0] req_op2;
    logic [3:0]  req_sel;
    logic [63:0] alu_op1;
    logic [63:0] alu_op2;
    logic [3:0]  alu_sel;
    logic [63:0] alu_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_zero;
    logic        rsp_err;
`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] stat_ops;
    logic [15:0] stat_errs;
`endif

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [65:0] sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_issue_ctrl #(.WIDTH(64), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op1   (req_op1),
        .req_op2   (req_op2),
        .req_sel   (req_sel),
        .alu_op1   (alu_op1),
        .alu_op2   (alu_op2),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .rsp_err   (rsp_err)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .stat_ops  (stat_ops),
        .stat_errs (stat_errs)
`endif
    );

    function automatic logic [63:0] alu_fn(logic [63:0] a, logic [63:0] b,
                                           logic [3:0] s);
        logic [6:0] sh;
        sh = {1'b0, b[5:0]};
        case (s)
            4'h0: return a & b;
            4'h1: return a | b;
            4'h2: return a + b;
            4'h3: return a - b;
            4'h4: return a * b;
            4'h5: return (b == 64'd0) ? 64'd0 : a / b;
            4'h6: return a << sh;
            4'h7: return a >> sh;
            4'h8: return (sh == 7'd0) ? a : ((a << sh) | (a >> (7'd64 - sh)));
            4'h9: return (sh == 7'd0) ? a : ((a >> sh) | (a << (7'd64 - sh)));
            4'hA: return ~(a | b);
            4'hB: return ~(a & b);
            4'hC: return a ^ b;
            4'hD: return ~(a ^ b);
            default: return 64'd0;
        endcase
    endfunction

    assign alu_out = alu_fn(alu_op1, alu_op2, alu_sel);

    // Expected response packed as {data, zero, err}.
    function automatic logic [65:0] exp_rsp(logic [63:0] a, logic [63:0] b,
                                            logic [3:0] s);
        logic [63:0] r;
        if (s >= 4'hE || (s == 4'h5 && b == 64'd0))
            return {64'd0, 1'b0, 1'b1};
        r = alu_fn(a, b, s);
        return {r, (r == 64'd0), 1'b0};
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Response monitor: every cycle a response is shown it must match
    // the scoreboard head; it is retired on the handshake.
    always @(negedge clk) begin
        logic [65:0] e;
        if (rsp_valid) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                e = sb_q[0];
                check("rsp_data", rsp_data, e[65:2]);
                check("rsp_zero", 64'(rsp_zero), 64'(e[1]));
                check("rsp_err", 64'(rsp_err), 64'(e[0]));
                if (rsp_ready) void'(sb_q.pop_front());
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until accepted; returns the accept
    // edge number. req_valid stays high for back-to-back use.
    task automatic send(input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] s, output int k);
        req_op1   = a;
        req_op2   = b;
        req_sel   = s;
        req_valid = 1'b1;
        k = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (req_ready) begin
                sb_q.push_back(exp_rsp(a, b, s));
                @(posedge clk);
                #1;
                k = cyc;
                return;
            end
        end
        check("accept_timeout", 64'd0, 64'd1);
        req_valid = 1'b0;
    endtask

    task automatic wait_valid(input int k, output int lat);
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = cyc - k;
                return;
            end
        end
        check("valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !rsp_valid) return;
        end
        check("drain_timeout", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        int k;
        int lat;
        logic [63:0] va [6];
        logic [63:0] vb [6];
        logic [3:0]  vs [6];

        rst       = 1'b1;
        req_valid = 1'b0;
        req_op1   = '0;
        req_op2   = '0;
        req_sel   = '0;
        rsp_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_alu_op1", alu_op1, 64'd0);
        check("rst_alu_op2", alu_op2, 64'd0);
        check("rst_alu_sel", 64'(alu_sel), 64'd0);
        check("rst_rsp_data", rsp_data, 64'd0);
        check("rst_rsp_zero", 64'(rsp_zero), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        rst = 1'b0;

        // ADD 5+7
        sync();
        send(64'd5, 64'd7, 4'b0010, k);
        req_valid = 1'b0;
        wait_valid(k, lat);
        check("add_latency", 64'(lat), 64'd3);
        check("add_value", rsp_data, 64'd12);
        drain();

        // SUB to zero
        sync();
        send(64'hDEAD_BEEF, 64'hDEAD_BEEF, 4'b0011, k);
        req_valid = 1'b0;
        wait_valid(k, lat);
        check("sub_latency", 64'(lat), 64'd3);
        check("sub_zero", 64'(rsp_zero), 64'd1);
        drain();

        // Divide by zero leaves ALU registers alone
        sync();
        send(64'd100, 64'd0, 4'b0101, k);
        req_valid = 1'b0;
        wait_valid(k, lat);
        check("div0_latency", 64'(lat), 64'd2);
        check("div0_err", 64'(rsp_err), 64'd1);
        check("div0_alu_sel", 64'(alu_sel), 64'd3);
        check("div0_alu_op1", alu_op1, 64'hDEAD_BEEF);
        drain();

        // Backpressure and ordering
        va = '{64'hA5A5_0000_FFFF_1234, 64'hFF00_FF00_1234_5678,
               64'h0000_00F0_0000_0000, 64'd123_456_789,
               64'h0F0F_0F0F_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF};
        vb = '{64'h0F0F_FFFF_0000_4321, 64'h0FF0_0FF0_FFFF_0000,
               64'h0000_000F_0000_0001, 64'd1000,
               64'h00F0_0000_0000_0010, 64'd2};
        vs = '{4'b1100, 4'b0000, 4'b0001, 4'b0100, 4'b1010, 4'b0010};
        sync();
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(va[i], vb[i], vs[i], k);
        req_op1 = va[5];
        req_op2 = vb[5];
        req_sel = vs[5];
        @(negedge clk);
        check("bp_full_after5", 64'(req_ready), 64'd0);
        repeat (3) @(negedge clk);
        check("bp_still_full", 64'(req_ready), 64'd0);
        check("bp_sb_depth", 64'(sb_q.size()), 64'd5);
        sync();
        rsp_ready = 1'b1;
        send(va[5], vb[5], vs[5], k);
        req_valid = 1'b0;
        drain();

        // Illegal select, then a legal OR
        sync();
        send(64'd1, 64'd2, 4'b1111, k);
        req_valid = 1'b0;
        wait_valid(k, lat);
        check("ill_latency", 64'(lat), 64'd2);
        check("ill_err", 64'(rsp_err), 64'd1);
        drain();
        sync();
        send(64'hF0, 64'h0F, 4'b0001, k);
        req_valid = 1'b0;
        wait_valid(k, lat);
        check("or_after_ill", rsp_data, 64'hFF);
        drain();

        // Random back-to-back burst
        sync();
        for (int i = 0; i < 12; i++) begin
            logic [63:0] a;
            logic [63:0] b;
            a = {$urandom, $urandom};
            b = (i % 4 == 1) ? 64'd0 : {32'd0, $urandom};
            send(a, b, 4'($urandom_range(0, 15)), k);
        end
        req_valid = 1'b0;
        drain();

        // Reset mid-flight
        sync();
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(64'(i + 10), 64'd3, 4'b0010, k);
        req_valid = 1'b0;
        wait_valid(k, lat);
        check("mid_rsp_valid", 64'(rsp_valid), 64'd1);
        #2;
        rst = 1'b1;
        sb_q.delete();
        #1;
        check("mid_rst_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        repeat (20) @(negedge clk);
        sync();
        send(64'h30, 64'h0C, 4'b0001, k);
        req_valid = 1'b0;
        wait_valid(k, lat);
        check("post_rst_latency", 64'(lat), 64'd3);
        check("post_rst_value", rsp_data, 64'h3C);
        drain();

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Initiator side of the 64-bit combinational ALU interface. Accepts operation requests {op1, op2, select} over a valid/ready handshake and buffers them in a small command FIFO. Drives the ALU operand/select inputs from registers, captures the ALU result, and returns it with zero and error flags over a valid/ready response handshake. Sits between the datapath control unit and the ALU instance.

Parameters:
WIDTH, 64, operand/result width; must match the ALU.
DEPTH, 4, command FIFO entries; a power of two, at least 2.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  FIFO can accept; equals !full
req_op1  in  WIDTH  operand 1
req_op2  in  WIDTH  operand 2
req_sel  in  4  ALU select code
alu_op1  out  WIDTH  registered to ALU Op1
alu_op2  out  WIDTH  registered to ALU Op2
alu_sel  out  4  registered to ALU select
alu_out  in  WIDTH  ALU result (combinational)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts
rsp_data  out  WIDTH  result
rsp_zero  out  1  1 when rsp_data == 0
rsp_err  out  1  illegal select or divide by zero

Behaviour:
- Reset (asynchronous): FIFO empty; FSM enters IDLE. alu_op1, alu_op2, alu_sel, rsp_data, rsp_valid, rsp_zero and rsp_err are all 0. req_ready is 1 after reset.
- Push: occurs when req_valid && req_ready. When the FIFO is full, req_ready=0 and no push occurs, even if a pop happens in the same cycle.
- FIFO: read and write pointers are log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH. Full and empty are derived from the pointer MSB and the lower bits.
- FSM states: IDLE, EXEC, RESP.
- IDLE, FIFO non-empty: pop one entry and check it.
  - If the entry is legal, register it onto alu_op1/alu_op2/alu_sel and go to EXEC.
  - If sel is 4'b1110 or 4'b1111, or sel==4'b0101 with op2==0: do not touch the alu_* registers. Load rsp_data=0, rsp_zero=0 and rsp_err=1, then go to RESP.
- EXEC (one cycle): capture rsp_data<=alu_out, rsp_zero<=(alu_out==0) and rsp_err<=0, then go to RESP.
- RESP: rsp_valid=1. rsp_data, rsp_zero and rsp_err hold stable until rsp_valid && rsp_ready. On that handshake, go to IDLE and drop rsp_valid on the next edge.
- Latency (idle FSM, empty FIFO, rsp_ready=1):
  - Legal request accepted at edge k: rsp_valid rises after edge k+3.
  - Error request: rsp_valid rises after edge k+2.
  - Sustained throughput is one result per 3 cycles.
- Ordering: responses return strictly in request order.
- Backpressure: the FIFO keeps accepting requests while in RESP until it is full.
- Reset mid-operation: pending entries and any in-flight response are discarded. No response is issued for them.
- alu_* registers are held between operations. They change only on a legal pop.

Optional Feature:
ALU_ISSUE_STATS_EN. When defined, the block adds these outputs:
- stat_ops (32 bits): counts legal operations completed in EXEC.
- stat_errs (16 bits): counts error responses.
Both counters reset to 0 on rst, saturate at their maximum value, and increment on the cycle the FSM enters RESP. When the macro is undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - The select constants: ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0011, ALU_MUL=0100, ALU_DIV=0101, ALU_SHL=0110, ALU_SHR=0111, ALU_ROL=1000, ALU_ROR=1001, ALU_NOR=1010, ALU_NAND=1011, ALU_XOR=1100, ALU_XNOR=1101.
  - The FSM state encoding.
  - A sel_is_legal function.
- Sub-module alu_cmd_fifo is a generic synchronous FIFO, (WIDTH*2+4) bits wide and DEPTH entries deep. It has push/pop/full/empty signals and an asynchronous active-high rst.

Test Plan:
- ADD: after reset, send op1=5, op2=7, sel=0010 with the ALU attached and rsp_ready=1. Expect rsp_valid 3 cycles after accept, rsp_data=12, rsp_zero=0, rsp_err=0.
- SUB to zero: send op1=op2=64'hDEAD_BEEF, sel=0011. Expect rsp_data=0, rsp_zero=1.
- Divide by zero: send sel=0101, op2=0. Expect rsp_err=1, rsp_data=0, response after 2 cycles, and alu_sel unchanged from the previous operation.
- Backpressure and ordering:
  - Hold rsp_ready=0 and push 6 back-to-back requests (XOR, AND, OR, MUL, NOR, ADD).
  - Expect req_ready=0 after 5 requests are accepted: 4 in the FIFO plus 1 held in RESP.
  - Release rsp_ready. Expect responses in request order with the correct values, and the response data stable while stalled.
- Illegal select: send sel=1111. Expect rsp_err=1. The next legal request (OR 0xF0|0x0F) returns 0xFF.
- Reset mid-flight: assert rst with 3 entries queued and rsp_valid=1. Expect rsp_valid=0 and req_ready=1 immediately, and no stale responses after rst deasserts.
